// File: rtl/serial_fifo_uart.sv
// UART with TX/RX FIFOs, 16x receive oversampling and sticky error flags, all in one clock domain.
// Optional even parity is compiled in with the SERIAL_PARITY_EN macro.
module serial_fifo_uart #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CLK_DIV         = 27
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Send,
    input  logic [DATA_BITS-1:0] DataIn,
    output logic                 TxFull,
    output logic                 TxIdle,
    input  logic                 Read,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 Valid,
    input  logic                 ClearErr,
    output logic                 Overrun,
    output logic                 FrameErr,
    output logic                 ParityErr,
    input  logic                 Receive,
    output logic                 Transmit
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [AW:0]   FULL_XOR = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

    // Free-running 16x oversample tick shared by both directions.
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) tick_cnt <= '0;
        else          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    // Handshakes: a word moves on a clock edge where Send is high and TxFull low
    // (TX side), or where Read and Valid are both high (RX side); otherwise nothing moves.

    // ---------------- transmit path ----------------
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [AW:0]          tx_wr, tx_rd, tx_wr_n, tx_rd_n;
    logic                 tx_push, tx_pop, tx_empty, tx_full_c;
    tx_state_t            tx_state, tx_state_n;
    logic [3:0]           tx_phase, tx_phase_n, tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n, tx_end, tx_line_n;

    assign tx_empty  = (tx_wr == tx_rd);
    assign tx_full_c = ((tx_wr ^ tx_rd) == FULL_XOR);
    assign tx_push   = Send & ~tx_full_c;
    assign tx_wr_n   = tx_wr + {{AW{1'b0}}, tx_push};
    assign tx_rd_n   = tx_rd + {{AW{1'b0}}, tx_pop};
    assign tx_end    = tick && (tx_phase == 4'd15);

    always_comb begin
        tx_state_n = tx_state;
        tx_phase_n = tick ? tx_phase + 4'd1 : tx_phase;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_phase_n = '0;
                tx_pop     = !tx_empty;
            end
            TX_START: if (tx_end) begin
                tx_state_n = TX_DATA;
                tx_bit_n   = '0;
            end
            TX_DATA: if (tx_end) begin
                tx_shift_n = tx_shift >> 1;
                tx_bit_n   = tx_bit + 4'd1;
                if (tx_bit == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
                    tx_state_n = TX_PARITY;
`else
                    tx_state_n = TX_STOP;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            TX_PARITY: if (tx_end) tx_state_n = TX_STOP;
`endif
            TX_STOP: if (tx_end) begin
                tx_state_n = TX_IDLE;
                tx_pop     = !tx_empty;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // A pop always starts a new frame, whether from IDLE or straight out of STOP.
        if (tx_pop) begin
            tx_state_n = TX_START;
            tx_phase_n = '0;
            tx_shift_n = tx_mem[tx_rd[AW-1:0]];
            tx_par_n   = ^tx_mem[tx_rd[AW-1:0]];
        end
        case (tx_state)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shift[0];
`ifdef SERIAL_PARITY_EN
            TX_PARITY: tx_line_n = tx_par;
`endif
            default:   tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= DataIn;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state <= TX_IDLE;
            tx_phase <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            Transmit <= 1'b1;
            TxFull   <= 1'b0;
            TxIdle   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_phase <= tx_phase_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_wr    <= tx_wr_n;
            tx_rd    <= tx_rd_n;
            Transmit <= tx_line_n;
            TxFull   <= ((tx_wr_n ^ tx_rd_n) == FULL_XOR);
            TxIdle   <= (tx_wr_n == tx_rd_n) && (tx_state_n == TX_IDLE);
        end
    end

    // ---------------- receive path ----------------
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [AW:0]          rx_wr, rx_rd, rx_wr_n, rx_rd_n;
    logic                 rx_push, rx_pop, rx_full;
    logic                 rx_s1, rx_s2, rx_prev;
    rx_state_t            rx_state, rx_state_n;
    logic [3:0]           rx_phase, rx_phase_n, rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_end, rx_par_ok, ovr_set, frame_set, par_set;

    assign rx_full = ((rx_wr ^ rx_rd) == FULL_XOR);
    assign rx_pop  = Read & Valid;
    assign rx_wr_n = rx_wr + {{AW{1'b0}}, rx_push};
    assign rx_rd_n = rx_rd + {{AW{1'b0}}, rx_pop};
    // START waits half a bit (8 ticks) to land mid-bit; every later sample is a full bit apart.
    assign rx_end  = tick && (rx_phase == ((rx_state == RX_START) ? 4'd7 : 4'd15));

`ifdef SERIAL_PARITY_EN
    logic rx_par_bad, rx_par_bad_n;
    assign rx_par_ok = !rx_par_bad;
`else
    assign rx_par_ok = 1'b1;
`endif

    always_comb begin
        rx_state_n = rx_state;
        rx_phase_n = tick ? rx_phase + 4'd1 : rx_phase;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
`ifdef SERIAL_PARITY_EN
        rx_par_bad_n = rx_par_bad;
`endif
        if (rx_end) rx_phase_n = '0;
        case (rx_state)
            RX_IDLE: begin
                rx_phase_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: if (rx_end) begin
                rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                rx_bit_n   = '0;
            end
            RX_DATA: if (rx_end) begin
                rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                rx_bit_n   = rx_bit + 4'd1;
                if (rx_bit == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
                    rx_state_n = RX_PARITY;
`else
                    rx_state_n = RX_STOP;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            RX_PARITY: if (rx_end) begin
                rx_par_bad_n = rx_s2 ^ (^rx_shift);
                par_set      = rx_par_bad_n;
                rx_state_n   = RX_STOP;
            end
`endif
            RX_STOP: if (rx_end) begin
                rx_state_n = RX_IDLE;
                if (!rx_s2) begin
                    frame_set = 1'b1;
                end else if (rx_par_ok) begin
                    // A pop in the same cycle frees the slot, so that is not an overrun.
                    if (rx_full && !rx_pop) ovr_set = 1'b1;
                    else                    rx_push = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_phase <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            Valid    <= 1'b0;
            DataOut  <= '0;
            Overrun  <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            rx_s1    <= Receive;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_phase <= rx_phase_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_wr    <= rx_wr_n;
            rx_rd    <= rx_rd_n;
            Valid    <= (rx_wr_n != rx_rd_n);
            // Head word, bypassing memory when the incoming word becomes the new head.
            if (rx_wr_n != rx_rd_n)
                DataOut <= (rx_push && (rx_rd_n[AW-1:0] == rx_wr[AW-1:0])) ?
                           rx_shift : rx_mem[rx_rd_n[AW-1:0]];
            Overrun  <= ovr_set | (Overrun & ~ClearErr);
            FrameErr <= frame_set | (FrameErr & ~ClearErr);
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_par_bad <= 1'b0;
            ParityErr  <= 1'b0;
        end else begin
            rx_par_bad <= rx_par_bad_n;
            ParityErr  <= par_set | (ParityErr & ~ClearErr);
        end
    end
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_fifo_uart.sv
// Directed-plus-random bench for serial_fifo_uart: serial frames are decoded/encoded by the bench
// and compared against queues of the words that should have crossed the link.
module tb_serial_fifo_uart;
    localparam int DB    = 8;
    localparam int NL    = 4;
    localparam int CD    = 4;
    localparam int BIT   = 16 * CD;
    localparam int DEPTH = 1 << NL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          send = 1'b0;
    logic          rd = 1'b0;
    logic          clr = 1'b0;
    logic          bench_rx = 1'b1;
    logic          loop = 1'b0;
    logic [DB-1:0] din = '0;
    logic          tx_full, tx_idle, valid, ovr, ferr, perr, txd;
    logic [DB-1:0] dout;
    wire           rxd;

    assign rxd = loop ? txd : bench_rx;

    always #5 clk = ~clk;

    serial_fifo_uart #(.DATA_BITS(DB), .FIFO_DEPTH_LOG2(NL), .CLK_DIV(CD)) dut (
        .Clock(clk), .Reset_n(rst_n), .Send(send), .DataIn(din), .TxFull(tx_full),
        .TxIdle(tx_idle), .Read(rd), .DataOut(dout), .Valid(valid), .ClearErr(clr),
        .Overrun(ovr), .FrameErr(ferr), .ParityErr(perr), .Receive(rxd), .Transmit(txd)
    );

    int checks = 0;
    int errors = 0;
    int tx_stop_bad = 0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] tx_exp_q[$];
    logic [DB-1:0] tx_got_q[$];
`ifdef SERIAL_PARITY_EN
    logic rx_par_flip = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Serial line driver: start, LSB-first data, optional parity, stop, then idle.
    task automatic rx_frame(input logic [DB-1:0] d, input logic stop_bit);
        bench_rx = 1'b0;
        repeat (BIT) cyc();
        for (int i = 0; i < DB; i++) begin
            bench_rx = d[i];
            repeat (BIT) cyc();
        end
`ifdef SERIAL_PARITY_EN
        bench_rx = (^d) ^ rx_par_flip;
        repeat (BIT) cyc();
`endif
        bench_rx = stop_bit;
        repeat (BIT) cyc();
        bench_rx = 1'b1;
        repeat (BIT / 4) cyc();
    endtask

    task automatic tx_word(input logic [DB-1:0] d);
        din  = d;
        send = 1'b1;
        cyc();
        send = 1'b0;
    endtask

    task automatic compare_tx(input string tag, input int n);
        check({tag, "_count"}, 32'(tx_got_q.size()), 32'(n));
        while (tx_got_q.size() > 0 && tx_exp_q.size() > 0)
            check({tag, "_word"}, 32'(tx_got_q.pop_front()), 32'(tx_exp_q.pop_front()));
        tx_got_q.delete();
        tx_exp_q.delete();
    endtask

    // Serial line monitor: decodes every frame seen on Transmit, sampling mid-bit.
    initial begin
        logic [DB-1:0] w;
        forever begin
            @(negedge txd);
            repeat (BIT / 2) @(posedge clk);
            for (int i = 0; i < DB; i++) begin
                repeat (BIT) @(posedge clk);
                #1 w[i] = txd;
            end
`ifdef SERIAL_PARITY_EN
            repeat (BIT) @(posedge clk);
            #1 if (txd !== ^w) tx_stop_bad++;
`endif
            repeat (BIT) @(posedge clk);
            #1 if (txd !== 1'b1) tx_stop_bad++;
            tx_got_q.push_back(w);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DB-1:0] w;
        int occ;
        int n;
        logic exp_ovr;

        // Reset
        repeat (5) @(posedge clk);
        #1;
        check("rst_transmit", 32'(txd), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_txfull", 32'(tx_full), 32'd0);
        check("rst_txidle", 32'(tx_idle), 32'd1);
        check("rst_dataout", 32'(dout), 32'd0);
        check("rst_flags", {29'd0, ovr, ferr, perr}, 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        check("post_rst_transmit", 32'(txd), 32'd1);
        check("post_rst_txidle", 32'(tx_idle), 32'd1);

        // Read on an empty FIFO is ignored
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        check("read_empty_valid", 32'(valid), 32'd0);

        // Single frame: latency and bit pattern
        din  = 8'hA5;
        send = 1'b1;
        cyc();
        send = 1'b0;
        tx_exp_q.push_back(8'hA5);
        check("tx_edge_k", 32'(txd), 32'd1);
        check("tx_busy", 32'(tx_idle), 32'd0);
        cyc();
        check("tx_edge_k1", 32'(txd), 32'd1);
        cyc();
        check("tx_edge_k2", 32'(txd), 32'd0);
        n = 0;
        while (n < 2000 && !(tx_got_q.size() >= 1 && tx_idle)) begin cyc(); n++; end
        compare_tx("tx_a5", 1);
        check("tx_idle_after", 32'(tx_idle), 32'd1);

        // TX FIFO fills while the shifter is busy; the overflowing word is dropped
        w = DB'($urandom);
        tx_word(w);
        tx_exp_q.push_back(w);
        repeat (3) cyc();
        occ = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            w = DB'($urandom);
            din  = w;
            send = 1'b1;
            if (occ < DEPTH) begin
                tx_exp_q.push_back(w);
                occ++;
            end
            cyc();
            check($sformatf("tx_full_%0d", i), 32'(tx_full), 32'(occ == DEPTH));
        end
        send = 1'b0;
        n = 0;
        while (n < 15000 && !(tx_got_q.size() >= DEPTH + 1 && tx_idle)) begin cyc(); n++; end
        compare_tx("tx_burst", DEPTH + 1);
        check("tx_stop_bits", 32'(tx_stop_bad), 32'd0);
        check("tx_idle_burst", 32'(tx_idle), 32'd1);

        // Loopback of two back-to-back words
        loop = 1'b1;
        tx_word(8'h3C);
        tx_word(8'hFF);
        tx_exp_q.push_back(8'h3C);
        tx_exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        n = 0;
        while (n < 2000 && !valid) begin cyc(); n++; end
        check("lb_valid", 32'(valid), 32'd1);
        check("lb_first", 32'(dout), 32'(exp_q[0]));
        n = 0;
        while (n < 3000 && !(tx_got_q.size() >= 2 && tx_idle)) begin cyc(); n++; end
        repeat (BIT) cyc();
        compare_tx("tx_lb", 2);
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        void'(exp_q.pop_front());
        check("lb_valid2", 32'(valid), 32'd1);
        check("lb_second", 32'(dout), 32'(exp_q[0]));
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        void'(exp_q.pop_front());
        check("lb_empty", 32'(valid), 32'd0);
        loop = 1'b0;

        // Overrun: 17 frames with no reads
        exp_ovr = 1'b0;
        for (int f = 0; f <= DEPTH; f++) begin
            w = DB'($urandom);
            rx_frame(w, 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else                      exp_ovr = 1'b1;
            check($sformatf("ovr_after_%0d", f), 32'(ovr), 32'(exp_ovr));
            repeat ($urandom_range(0, 20)) cyc();
        end
        while (exp_q.size() > 0) begin
            check("ovr_drain_valid", 32'(valid), 32'd1);
            check("ovr_drain_data", 32'(dout), 32'(exp_q.pop_front()));
            rd = 1'b1;
            cyc();
            rd = 1'b0;
        end
        check("ovr_drain_empty", 32'(valid), 32'd0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'd0);

        // Framing error: stop bit low
        rx_frame(DB'($urandom), 1'b0);
        repeat (20) cyc();
        check("ferr_set", 32'(ferr), 32'd1);
        check("ferr_no_word", 32'(valid), 32'd0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("ferr_cleared", 32'(ferr), 32'd0);
        w = DB'($urandom);
        rx_frame(w, 1'b1);
        check("recover_valid", 32'(valid), 32'd1);
        check("recover_data", 32'(dout), 32'(w));
        rd = 1'b1;
        cyc();
        rd = 1'b0;

        // Short glitch on the line is not a start bit
        bench_rx = 1'b0;
        repeat (10) cyc();
        bench_rx = 1'b1;
        repeat (12 * BIT) cyc();
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_ferr", 32'(ferr), 32'd0);

`ifdef SERIAL_PARITY_EN
        rx_par_flip = 1'b1;
        rx_frame(8'h01, 1'b1);
        rx_par_flip = 1'b0;
        check("perr_set", 32'(perr), 32'd1);
        check("perr_discard", 32'(valid), 32'd0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("perr_cleared", 32'(perr), 32'd0);
`else
        check("perr_tied", 32'(perr), 32'd0);
`endif

        // Reset in the middle of a frame of zeros
        tx_word(8'h00);
        repeat (3 * BIT) cyc();
        check("mid_frame_low", 32'(txd), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_transmit", 32'(txd), 32'd1);
        check("async_rst_txidle", 32'(tx_idle), 32'd1);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (2 * BIT) cyc();
        check("after_abort_transmit", 32'(txd), 32'd1);
        check("after_abort_idle", 32'(tx_idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
